clk_div_gen: RTL
================

# clk_div_gen

Multi-channel programmable clock-enable and divided-clock generator. It supersedes the fixed power-of-two divider in the bus comparator timing path. Each of NCH channels has a runtime-programmable integer divisor and produces two registered outputs: a ~50% duty divided clock and a one-cycle tick. Divisor changes are glitch-free: they are staged and applied only at the channel's wrap point. A global sync input realigns all channels.

## Interface
- NCH, 4: number of channels, 1..CW-1.
- CW, 16: counter/divisor width in bits.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  global run; 0 freezes all counters.
- sync  in  1  one-cycle request to realign all channels.
- cfg_wr  in  1  divisor write request.
- cfg_ch  in  max(1,$clog2(NCH))  target channel of the write.
- cfg_div  in  CW  new divisor N (period in clk cycles).
- cfg_rdy  out  1  write accepted when cfg_wr && cfg_rdy; combinational, = (cfg_ch < NCH) && !pending[cfg_ch].
- div_out  out  NCH  divided clocks, registered.
- tick  out  NCH  one-cycle wrap pulses, registered.

## Operation
- Per channel i, state is: cnt[CW] (0..N-1), div_reg[CW], stage_reg[CW], pending flag.
- Reset values: cnt=0, div_reg=2^(i+1) (2, 4, 8, 16…), stage_reg=0, pending=0, div_out=0, tick=0.
- Channel is valid iff div_reg ≥ 2. An invalid channel holds cnt=0, div_out=0, tick=0.
- Normal step (en=1, sync=0, valid): cnt_new = (cnt==N-1) ? 0 : cnt+1. tick <= (cnt_new==0). div_out <= (cnt_new < N>>1).
- Odd N: high phase is floor(N/2) cycles; low phase is ceil(N/2) cycles.
- Accepted write: stage_reg <= cfg_div, pending <= 1.
- Pending divisor applies on the edge where cnt_new==0 (wrap). On that edge, div_reg <= stage_reg and pending <= 0, and div_out is computed with the new N.
- If the channel is invalid when a write is pending, it applies on the next edge with en=1 (cnt stays 0).
- en=0: cnt, div_reg and div_out hold; tick forced 0. Writes are still accepted and remain pending.
- sync=1 (priority over en and over wrap) applies to every channel:
  - pending divisor applied, pending cleared;
  - cnt <= 0, tick <= 0, div_out <= (0 < N>>1), using the post-apply N.
- Simultaneous write and wrap on the same channel: the write is staged; it applies at the following wrap, not the current one.
- Simultaneous write and sync: the write is staged after sync applies; it waits for the next wrap.
- Writes with cfg_ch ≥ NCH are ignored (cfg_rdy=0).
- rst mid-operation: all state returns to reset values on that edge; pending writes are discarded.

## Timing
- Outputs are registered. Latency from cnt change to output update is zero extra cycles.
- From rst deassert with en=1: first tick on channel i appears after N cycles (2^(i+1)).
- tick period = N cycles; pulse width = 1 cycle.
- div_out period = N cycles.
- cfg_rdy is valid in the same cycle as cfg_ch. The handshake completes in one cycle.
- Divisor change takes effect at most N_old cycles after acceptance (the next wrap).
- sync takes effect on the next edge. The first post-sync tick occurs N cycles later.

## Configuration
- Macro: CLKDIV_PHASE_EN.
- Defined: adds input cfg_phase [CW], captured with cfg_div into stage_phase. On sync, cnt loads the phase value instead of 0, or 0 if phase ≥ N. div_out and tick are computed from the loaded value, with tick forced 0 on sync.
- Undefined: the cfg_phase port does not exist and sync always loads 0.

## Test plan
- Reset, en=1 for 64 cycles, NCH=4 defaults -> ticks every 2/4/8/16 cycles; div_out square waves matching bits 0..3 of a free counter.
- Write ch1 N=5 mid-period -> cfg_rdy drops; old period 4 completes; then ticks every 5; div_out high 2, low 3.
- Write ch0 N=1, then N=3 -> channel outputs stay 0 while N=1; N=3 applies on the next en cycle; tick period 3.
- en low 10 cycles mid-count with a write accepted -> outputs frozen, tick=0; resumes from the same cnt; new N applies at the wrap.
- sync with pending writes on ch2 (N=6) and ch3 (N=7) -> both apply immediately; div_out=1 next cycle; first ticks 6 and 7 cycles later.
- rst asserted while pending=1 -> pending cleared, divisors back to defaults, all outputs 0 next cycle.

Source files
------------

// File: rtl/clk_div_gen.sv
// clk_div_gen: multi-channel programmable clock-enable / divided-clock generator.
// Each channel counts 0..N-1 and drives a ~50% duty divided clock (div_out)
// plus a one-cycle wrap pulse (tick). New divisors are staged and only take
// effect at the channel's wrap point (or on sync), so outputs never glitch.
// Optional feature macro: CLKDIV_PHASE_EN adds cfg_phase, the count loaded on sync.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   en            global run enable (0 freezes counters, forces tick low)
//   sync          one-cycle realign request for all channels
//   cfg_wr/ch/div divisor write request, target channel, new divisor
//   cfg_phase     sync load phase (CLKDIV_PHASE_EN only)
//   cfg_rdy       combinational write-accept indication
//   div_out/tick  registered per-channel divided clock and wrap pulse
module clk_div_gen #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 16,
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           sync,
    input  logic           cfg_wr,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
`ifdef CLKDIV_PHASE_EN
    input  logic [CW-1:0]  cfg_phase,
`endif
    output logic           cfg_rdy,
    output logic [NCH-1:0] div_out,
    output logic [NCH-1:0] tick
);

    logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NCH-1:0][CW-1:0] div_q, div_d;
    logic [NCH-1:0][CW-1:0] stage_q, stage_d;
    logic [NCH-1:0]         pending_q, pending_d;
    logic [NCH-1:0]         div_out_q, div_out_d;
    logic [NCH-1:0]         tick_q, tick_d;
`ifdef CLKDIV_PHASE_EN
    logic [NCH-1:0][CW-1:0] stage_phase_q, stage_phase_d;
`endif

    // Accept only in-range channels with no divisor already waiting.
    always_comb begin
        cfg_rdy = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == CHW'(i)) begin
                cfg_rdy = !pending_q[i];
            end
        end
    end

    // Per-channel next-state: sync > freeze > invalid-divisor > normal count.
    always_comb begin
        logic [CW-1:0] n_eff;
        logic [CW-1:0] n_nx;
        logic [CW-1:0] cnt_nx;
        logic [CW-1:0] ld;
        logic          wr_hit;

        cnt_d     = cnt_q;
        div_d     = div_q;
        stage_d   = stage_q;
        pending_d = pending_q;
        div_out_d = div_out_q;
        tick_d    = tick_q;
`ifdef CLKDIV_PHASE_EN
        stage_phase_d = stage_phase_q;
`endif
        n_eff  = '0;
        n_nx   = '0;
        cnt_nx = '0;
        ld     = '0;
        wr_hit = 1'b0;

        for (int i = 0; i < NCH; i++) begin
            wr_hit = cfg_wr && cfg_rdy && (cfg_ch == CHW'(i));
            n_eff  = pending_q[i] ? stage_q[i] : div_q[i];

            if (sync) begin
                // Pending divisor applies immediately; count restarts.
`ifdef CLKDIV_PHASE_EN
                ld = (stage_phase_q[i] < n_eff) ? stage_phase_q[i] : '0;
`else
                ld = '0;
`endif
                div_d[i]     = n_eff;
                pending_d[i] = 1'b0;
                cnt_d[i]     = ld;
                tick_d[i]    = 1'b0;
                div_out_d[i] = (ld < (n_eff >> 1));
            end else if (!en) begin
                tick_d[i] = 1'b0;
            end else if (div_q[i] < CW'(2)) begin
                // Invalid divisor: park at zero, take any staged divisor now.
                cnt_d[i]     = '0;
                div_out_d[i] = 1'b0;
                tick_d[i]    = 1'b0;
                if (pending_q[i]) begin
                    div_d[i]     = stage_q[i];
                    pending_d[i] = 1'b0;
                end
            end else begin
                cnt_nx = (cnt_q[i] == div_q[i] - CW'(1)) ? '0 : cnt_q[i] + CW'(1);
                n_nx   = div_q[i];
                if ((cnt_nx == '0) && pending_q[i]) begin
                    n_nx         = stage_q[i];
                    div_d[i]     = stage_q[i];
                    pending_d[i] = 1'b0;
                end
                cnt_d[i]     = cnt_nx;
                tick_d[i]    = (cnt_nx == '0);
                div_out_d[i] = (cnt_nx < (n_nx >> 1));
            end

            // A write can only land while nothing is pending, so it always
            // waits for a later wrap or sync.
            if (wr_hit) begin
                stage_d[i]   = cfg_div;
                pending_d[i] = 1'b1;
`ifdef CLKDIV_PHASE_EN
                stage_phase_d[i] = cfg_phase;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            stage_q   <= '0;
            pending_q <= '0;
            div_out_q <= '0;
            tick_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                div_q[i] <= CW'(1) << (i + 1);
            end
`ifdef CLKDIV_PHASE_EN
            stage_phase_q <= '0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            stage_q   <= stage_d;
            pending_q <= pending_d;
            div_out_q <= div_out_d;
            tick_q    <= tick_d;
`ifdef CLKDIV_PHASE_EN
            stage_phase_q <= stage_phase_d;
`endif
        end
    end

    assign div_out = div_out_q;
    assign tick    = tick_q;

endmodule
